// File: rtl/register_file.sv
// register_file: 32x32 MIPS GPR file, two combinational reads, one sync write, r0 hardwired to zero
module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_live, byp_rs, byp_rt;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end
  // A write that will land this edge; reset suppresses both the write and its bypass
  assign wr_live = wr_en && !reset && (wr_addr != '0);
  always_comb begin
    byp_rs  = (BYPASS != 0) && wr_live && (wr_addr == rs_addr);
    byp_rt  = (BYPASS != 0) && wr_live && (wr_addr == rt_addr);
    rs_data = (rs_addr == '0) ? '0 : byp_rs ? wr_data : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : byp_rt ? wr_data : regs[rt_addr];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plan plus random traffic on bypass and non-bypass instances vs an array model
module tb_register_file;
  logic        clk = 0;
  logic        reset = 1;
  logic [4:0]  rs_addr = 0, rt_addr = 0, wr_addr = 0;
  logic        wr_en = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] rs1, rt1, rs0, rt0;
  logic [31:0] mem [32];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  register_file #(.BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
  register_file #(.BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && wr_en && !reset && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  task automatic rd(input string tag);
    #1;
    chk({tag, "_rs_b1"}, rs1, exp_rd(rs_addr, 1));
    chk({tag, "_rt_b1"}, rt1, exp_rd(rt_addr, 1));
    chk({tag, "_rs_b0"}, rs0, exp_rd(rs_addr, 0));
    chk({tag, "_rt_b0"}, rt0, exp_rd(rt_addr, 0));
  endtask

  task automatic tick();
    if (reset) for (int i = 0; i < 32; i++) mem[i] = 0;
    else if (wr_en && wr_addr != 0) mem[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  initial begin
    tick();
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      rd("post_reset");
    end
    // reset clears a written register
    wr(5, 32'hDEADBEEF);
    rs_addr = 5; rt_addr = 31;
    rd("pre_clear");
    chk("r5_written", rs1, 32'hDEADBEEF);
    reset = 1; tick(); reset = 0;
    rd("reset_clear");
    chk("r5_cleared", rs1, 32'h0);
    // basic write/read on both ports
    wr(8, 32'h1);
    rs_addr = 8; rt_addr = 8;
    rd("basic");
    chk("r8_value", rt0, 32'h1);
    // r0 ignores writes and never bypasses
    wr(0, 32'hFFFFFFFF);
    rs_addr = 0; rt_addr = 0;
    rd("zero");
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    rd("zero_held");
    chk("r0_no_byp", rs1, 32'h0);
    tick(); wr_en = 0;
    // write-through bypass vs stored value
    wr(9, 32'h10);
    wr_en = 1; wr_addr = 9; wr_data = 32'h20; rs_addr = 9; rt_addr = 8;
    rd("bypass_pre");
    chk("byp1_new", rs1, 32'h20);
    chk("byp0_old", rs0, 32'h10);
    tick(); wr_en = 0;
    rd("bypass_post");
    chk("byp0_after", rs0, 32'h20);
    // reset beats a same-cycle write, and disables the bypass
    wr(3, 32'hA5A5A5A5);
    reset = 1; wr_en = 1; wr_addr = 3; wr_data = 32'h12345678; rs_addr = 3; rt_addr = 3;
    rd("reset_write_pre");
    chk("rst_no_byp", rs1, 32'hA5A5A5A5);
    tick(); reset = 0; wr_en = 0;
    rd("reset_write_post");
    chk("r3_zero", rt1, 32'h0);
    // sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int k = 0; k < 3; k++) tick();
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      rd("sweep");
      chk("sweep_abs", rs0, 32'(i) * 32'h01010101);
    end
    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 29) == 0);
      wr_en   = $urandom_range(0, 2) != 0;
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom);
      rd("rand");
      tick();
    end
    reset = 0; wr_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
MIPS general-purpose register file, 32 x 32-bit, two combinational read ports and one synchronous write port. It is the write-back consumer of the 2:1 result mux: the mux output drives wr_data.
Read data rs_data/rt_data feed the ALU operand mux downstream. Register 0 is hardwired to zero. An optional write-through bypass resolves same-cycle write/read hazards.

Parameters:
WIDTH, 32, data width of each register
ADDR_W, 5, address width; depth = 2**ADDR_W (32 registers)
BYPASS, 1, 1 = read ports return wr_data when reading the register being written this cycle; 0 = read returns the old stored value

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
rs_addr  input  ADDR_W  read port A address
rt_addr  input  ADDR_W  read port B address
rs_data  output  WIDTH  read port A data (combinational)
rt_data  output  WIDTH  read port B data (combinational)
wr_en  input  1  write enable (RegWrite)
wr_addr  input  ADDR_W  write address (from RegDst mux)
wr_data  input  WIDTH  write data (from write-back result mux)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high: on a rising clk edge with reset=1, every register 0..2**ADDR_W-1 is cleared to 0.
- Reset priority: reset=1 overrides wr_en in the same cycle; no write occurs.
- Reset mid-operation: a write presented in the reset cycle is discarded. Writes resume on the first edge with reset=0.
- Write: on a rising clk edge with reset=0, wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. The new value is visible from the stored array starting the next cycle.
- Write to address 0 is ignored; reg[0] is never nonzero.
- Reads are combinational, with zero-cycle latency from address to data:
  - rs_addr==0 -> rs_data = 0, regardless of bypass or any write.
  - If BYPASS=1, wr_en=1, reset=0, wr_addr==rs_addr and rs_addr!=0 -> rs_data = wr_data (write-through).
  - Otherwise rs_data = reg[rs_addr].
  - rt_data follows identical rules using rt_addr.
- Both read ports may address the same register, and may match wr_addr, simultaneously. Both ports return the same value under the rules above.
- During a reset cycle (reset=1), the bypass is disabled and reads return stored values. After the reset edge, all reads return 0.
- Output reset value: rs_data = rt_data = 0 for every address after reset, until written.
- Before the first reset, contents are undefined (X in simulation). The bench must reset first.
- No wrap-around: the address width exactly covers the depth, so every address is valid.

Test Plan:
- Reset clears: write 32'hDEADBEEF to r5, then hold reset=1 for 1 cycle -> rs_addr=5 gives rs_data=0; rt_addr=31 gives rt_data=0.
- Basic write/read: wr_en=1, wr_addr=8, wr_data=32'h00000001, one edge; then rs_addr=8, rt_addr=8 -> both ports read 32'h00000001.
- Zero register: wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF, one edge -> rs_addr=0 gives 0; with wr_addr=0 held during the read, still 0 (no bypass on r0).
- Bypass: r9=32'h00000010 stored; same cycle wr_en=1, wr_addr=9, wr_data=32'h00000020, rs_addr=9 -> BYPASS=1: rs_data=32'h20 before the edge; BYPASS=0: rs_data=32'h10 before the edge, 32'h20 after.
- Reset beats write: reset=1, wr_en=1, wr_addr=3, wr_data=32'h12345678, one edge -> r3 reads 0 afterwards; rs_data is not bypassed during the reset cycle.
- Sweep: write r[i]=i*32'h01010101 for i=1..31, then read all pairs (i, 31-i) -> exact values; r0=0; wr_en=0 cycles leave contents unchanged.
